// File: rtl/i2s_rx_multi.sv
// i2s_rx_multi: multi-lane I2S receiver front-end.
// NCH serial data lines share one ws/sck pair. Each accepted slot yields one
// channel-aligned word set, delivered through a single valid/ready holding
// register. Also provides overrun counting, frame-error detection and a
// per-channel commit mask.
// Optional build macro I2S_RX_RIGHT_SLOT_EN: when defined, right slots (ws=1)
// are captured and committed as well and tagged via dout_right. When it is
// undefined, only left slots are accepted and dout_right stays 0.
`timescale 1ns/1ps

module i2s_rx_multi #(
    parameter int NCH         = 4,
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ws,
    input  logic                 sck,
    input  logic [NCH-1:0]       sd,
    input  logic [NCH-1:0]       ch_en,
    output logic [NCH*WIDTH-1:0] dout,
    output logic                 dout_vld,
    input  logic                 dout_rdy,
    output logic                 dout_right,
    output logic                 overrun,
    output logic [7:0]           ovr_cnt,
    output logic                 frame_err
);

`ifdef I2S_RX_RIGHT_SLOT_EN
    localparam bit RIGHT_EN = 1'b1;
`else
    localparam bit RIGHT_EN = 1'b0;
`endif

    localparam int CW = $clog2(WIDTH + 1);

    // Synchroniser chains: index 0 is the first flop, SYNC_STAGES-1 the output.
    logic [SYNC_STAGES-1:0] ws_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [NCH-1:0]         sd_sync [SYNC_STAGES];

    logic           ws_s;
    logic           sck_s;
    logic [NCH-1:0] sd_s;

    // Slot tracking state
    logic          sck_prev;
    logic          ws_prev;
    logic          slot;
    logic          locked;
    logic [CW-1:0] bit_cnt;

    // Per-lane shift registers and commit request
    logic [WIDTH-1:0]     shreg [NCH];
    logic                 commit_pend;
    logic [NCH*WIDTH-1:0] masked;

    logic rise;
    logic ws_chg;
    logic slot_ok;
    logic cnt_full;
    logic capture;
    logic last_bit;

    assign ws_s  = ws_sync[SYNC_STAGES-1];
    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign sd_s  = sd_sync[SYNC_STAGES-1];

    // A slot is accepted if it is a left slot, or right slots are enabled.
    assign slot_ok  = RIGHT_EN | ~slot;
    assign rise     = sck_s & ~sck_prev;
    assign ws_chg   = rise & (ws_s != ws_prev);
    assign cnt_full = (bit_cnt == CW'(WIDTH));
    // The bit on a ws-change edge belongs to the previous slot's tail.
    // Capture stays off after reset until the first ws change is seen.
    assign capture  = rise & ~ws_chg & locked & ~cnt_full;
    assign last_bit = capture & slot_ok & (bit_cnt == CW'(WIDTH - 1));

    // Bring ws, sck and every sd lane into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_sync  <= '1;
            sck_sync <= '0;
            // NOTE: the sync array is small control state, so it is reset like
            // any other flop; only true storage arrays may skip reset.
            for (int s = 0; s < SYNC_STAGES; s++) sd_sync[s] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every stage reading the
            // previous cycle's value, which is what makes this a shift chain.
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            sd_sync[0] <= sd;
            for (int s = 1; s < SYNC_STAGES; s++) sd_sync[s] <= sd_sync[s-1];
        end
    end

    // Slot boundary detection, bit counting and frame-error flagging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_prev    <= 1'b0;
            ws_prev     <= 1'b1;
            slot        <= 1'b0;
            locked      <= 1'b0;
            bit_cnt     <= '0;
            frame_err   <= 1'b0;
            commit_pend <= 1'b0;
        end else begin
            sck_prev    <= sck_s;
            frame_err   <= 1'b0;
            commit_pend <= last_bit;
            if (ws_chg) begin
                ws_prev   <= ws_s;
                slot      <= ws_s;
                bit_cnt   <= '0;
                locked    <= 1'b1;
                // A partial word in an accepted slot is discarded and flagged.
                frame_err <= locked & slot_ok & (bit_cnt != '0) & ~cnt_full;
            end else if (capture) begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    // Shift each lane MSB first while the slot still needs bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) shreg[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < NCH; i++) shreg[i] <= {shreg[i][WIDTH-2:0], sd_s[i]};
        end
    end

    // Apply the channel-enable mask to the captured word set.
    always_comb begin
        // NOTE: default assignment first, so no path leaves masked unassigned
        // and no latch is inferred.
        masked = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_en[i]) masked[i*WIDTH +: WIDTH] = shreg[i];
        end
    end

    // Holding register with valid/ready handshake and overrun accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_vld   <= 1'b0;
            dout_right <= 1'b0;
            overrun    <= 1'b0;
            ovr_cnt    <= '0;
        end else begin
            overrun <= 1'b0;
            if (commit_pend && (!dout_vld || dout_rdy)) begin
                dout       <= masked;
                dout_right <= RIGHT_EN & slot;
                dout_vld   <= 1'b1;
            end else begin
                if (dout_vld && dout_rdy) dout_vld <= 1'b0;
                if (commit_pend) begin
                    overrun <= 1'b1;
                    if (ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_multi.sv
// Self-checking bench for i2s_rx_multi. Expected word sets are queued as
// stimulus is driven and compared when the DUT hands a set over.
// Honours I2S_RX_RIGHT_SLOT_EN in the same way as the design.
`timescale 1ns/1ps

module tb_i2s_rx_multi;

    localparam int NCH         = 4;
    localparam int WIDTH       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int SCK_HALF    = 20;
    localparam int DW          = NCH * WIDTH;

`ifdef I2S_RX_RIGHT_SLOT_EN
    localparam int RIGHT_EN = 1;
`else
    localparam int RIGHT_EN = 0;
`endif

    logic           clk;
    logic           rst_n;
    logic           ws;
    logic           sck;
    logic [NCH-1:0] sd;
    logic [NCH-1:0] ch_en;
    logic [DW-1:0]  dout;
    logic           dout_vld;
    logic           dout_rdy;
    logic           dout_right;
    logic           overrun;
    logic [7:0]     ovr_cnt;
    logic           frame_err;

    i2s_rx_multi #(.NCH(NCH), .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ws         (ws),
        .sck        (sck),
        .sd         (sd),
        .ch_en      (ch_en),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .dout_rdy   (dout_rdy),
        .dout_right (dout_right),
        .overrun    (overrun),
        .ovr_cnt    (ovr_cnt),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          right;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int      n_hs   = 0;
    int      n_ovr  = 0;
    int      n_ferr = 0;
    bit      lat_arm = 0;
    longint  t_last  = 0;
    logic    vld_q   = 1'b0;
    logic    hold_q  = 1'b0;
    logic [DW-1:0] dout_q  = '0;
    logic          right_q = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mask_set(input logic [DW-1:0] w, input logic [NCH-1:0] en);
        mask_set = '0;
        for (int i = 0; i < NCH; i++) begin
            if (en[i]) mask_set[i*WIDTH +: WIDTH] = w[i*WIDTH +: WIDTH];
        end
    endfunction

    // Sampled just after each negedge: the values seen here are exactly what
    // the DUT will act on at the following posedge.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (dout_vld && !vld_q && lat_arm) begin
                check("latency", DW'(($time - t_last - 1) / 10), DW'(SYNC_STAGES + 2));
                lat_arm = 0;
            end
            if (hold_q && dout_vld) begin
                check("hold_dout", dout, dout_q);
                check("hold_right", dout_right, right_q);
            end
            if (dout_vld && dout_rdy) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    check("unexpected_set", dout, '0);
                    check("unexpected_count", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", dout, e.data);
                    check("dout_right", dout_right, e.right);
                end
            end
            if (overrun)   n_ovr++;
            if (frame_err) n_ferr++;
        end
        vld_q   = dout_vld;
        hold_q  = dout_vld && !dout_rdy;
        dout_q  = dout;
        right_q = dout_right;
    end

    task automatic sck_bit(input logic w, input logic [NCH-1:0] d, input bit mark);
        sck = 1'b0;
        ws  = w;
        sd  = d;
        #SCK_HALF;
        sck = 1'b1;
        if (mark) t_last = $time;
        #SCK_HALF;
    endtask

    // One slot: boundary bit, then nbits MSB-first data bits, padded to total.
    task automatic send_slot(input logic w, input logic [DW-1:0] words, input int nbits, input int total);
        logic [NCH-1:0] d;
        sck_bit(w, '0, 1'b0);
        for (int k = 1; k < total; k++) begin
            d = '0;
            if (k <= nbits) begin
                for (int i = 0; i < NCH; i++) d[i] = words[i*WIDTH + WIDTH - k];
            end
            sck_bit(w, d, (k == WIDTH));
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] left, input logic [DW-1:0] right,
                              input int total, input bit push);
        if (push) exp_q.push_back('{data: mask_set(left, ch_en), right: 1'b0});
        send_slot(1'b0, left, WIDTH, total);
        if (push && RIGHT_EN != 0) exp_q.push_back('{data: mask_set(right, ch_en), right: 1'b1});
        send_slot(1'b1, right, WIDTH, total);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, dout, '0);
        check({tag, "_vld"}, dout_vld, '0);
        check({tag, "_right"}, dout_right, '0);
        check({tag, "_overrun"}, overrun, '0);
        check({tag, "_ovr_cnt"}, ovr_cnt, '0);
        check({tag, "_frame_err"}, frame_err, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs0, fe0, ov0;
        logic [DW-1:0] w;

        rst_n    = 1'b0;
        ws       = 1'b1;
        sck      = 1'b0;
        sd       = '0;
        ch_en    = '1;
        dout_rdy = 1'b1;
        #40;
        check_reset_outputs("reset");
        #20 rst_n = 1'b1;
        #40;

        // 1: basic left-slot capture and latency
        hs0 = n_hs;
        lat_arm = 1;
        send_frame({16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234}, {4{16'h0000}}, 32, 1'b1);
        #200;
        check("t1_sets", n_hs - hs0, 1 + RIGHT_EN);
        check("t1_latency_seen", lat_arm, 1'b0);
        check("t1_queue", exp_q.size(), 0);

        // 2a: consumer stalled over three frames
        dout_rdy = 1'b0;
        ov0 = n_ovr;
        exp_q.push_back('{data: {16'h1111, 16'h2222, 16'h3333, 16'h4444}, right: 1'b0});
        send_frame({16'h1111, 16'h2222, 16'h3333, 16'h4444}, {4{16'h0BAD}}, 32, 1'b0);
        send_frame({4{16'h5555}}, {4{16'h0BAD}}, 32, 1'b0);
        send_frame({4{16'h6666}}, {4{16'h0BAD}}, 32, 1'b0);
        #200;
        check("t2_overrun_pulses", n_ovr - ov0, 2 + 3 * RIGHT_EN);
        check("t2_ovr_cnt", ovr_cnt, 8'(2 + 3 * RIGHT_EN));
        check("t2_vld_held", dout_vld, 1'b1);
        dout_rdy = 1'b1;
        #100;
        check("t2_queue", exp_q.size(), 0);

        // 2b: saturation of the drop counter
        dout_rdy = 1'b0;
        exp_q.push_back('{data: {4{16'hC0DE}}, right: 1'b0});
        for (int f = 0; f < 300; f++) begin
            w = (f == 0) ? {4{16'hC0DE}} : {4{16'(f)}};
            send_frame(w, {4{16'(f + 7)}}, 18, 1'b0);
        end
        #200;
        check("t2_ovr_sat", ovr_cnt, 8'd255);
        dout_rdy = 1'b1;
        #100;
        check("t2b_queue", exp_q.size(), 0);

        // 3: channel enable mask
        ch_en = 4'b0101;
        send_frame({4{16'hAAAA}}, {4{16'hAAAA}}, 32, 1'b1);
        #200;
        check("t3_queue", exp_q.size(), 0);
        ch_en = '1;

        // 4: frame error after 9 left bits
        fe0 = n_ferr;
        hs0 = n_hs;
        send_slot(1'b0, {4{16'hFACE}}, 9, 10);
        if (RIGHT_EN != 0) exp_q.push_back('{data: {4{16'h0F0F}}, right: 1'b1});
        send_slot(1'b1, {4{16'h0F0F}}, WIDTH, 32);
        #200;
        check("t4_frame_err", n_ferr - fe0, 1);
        check("t4_no_commit", n_hs - hs0, RIGHT_EN);
        send_frame({16'h0102, 16'h0304, 16'h0506, 16'h0708}, {4{16'h0000}}, 32, 1'b1);
        #200;
        check("t4_recover", exp_q.size(), 0);
        check("t4_no_more_err", n_ferr - fe0, 1);

        // 5: reset mid-word
        hs0 = n_hs;
        send_slot(1'b0, {4{16'hDEAD}}, 8, 9);
        rst_n = 1'b0;
        #30;
        check_reset_outputs("t5_reset");
        ws = 1'b1;
        #20 rst_n = 1'b1;
        #40;
        send_slot(1'b1, {4{16'hBEEF}}, WIDTH, 32);
        send_frame({16'h5A5A, 16'hA5A5, 16'h0FF0, 16'hF00F}, {4{16'h1357}}, 32, 1'b1);
        #200;
        check("t5_sets", n_hs - hs0, 1 + RIGHT_EN);
        check("t5_queue", exp_q.size(), 0);
        check("t5_ovr_cnt", ovr_cnt, 8'd0);

        // 6: left/right slot tagging
        hs0 = n_hs;
        send_frame({4{16'h0001}}, {4{16'h0002}}, 32, 1'b1);
        #200;
        check("t6_sets", n_hs - hs0, 1 + RIGHT_EN);
        check("t6_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
